// File: rtl/accel_status_pkg.sv
// Shared state encoding and default sizing for the accelerator status LED block.
package accel_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int DEF_NUM_CORES   = 4;
  localparam int DEF_BLINK_DIV   = 25_000_000;
  localparam int DEF_TIMEOUT_CYC = 100_000_000;

endpackage

// File: rtl/blink_prescaler.sv
// Blink generator: counts 0..BLINK_DIV-1 while enabled and toggles blink on each wrap.
// clr restarts from zero; when clr and en are both high the clearing edge also
// counts as the first tick of the new period.
module blink_prescaler
  import accel_status_pkg::*;
#(
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic blink
);

  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_base;
  logic          blink_base;

  // Starting point for this cycle: zero when cleared, otherwise the held values
  always_comb begin
    cnt_base   = clr ? '0 : cnt;
    blink_base = clr ? 1'b0 : blink;
  end

  // Prescaler and blink bit; wrap toggles blink
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (en) begin
      if (cnt_base == CW'(BLINK_DIV - 1)) begin
        cnt   <= '0;
        blink <= ~blink_base;
      end else begin
        cnt   <= cnt_base + 1'b1;
        blink <= blink_base;
      end
    end else begin
      cnt   <= cnt_base;
      blink <= blink_base;
    end
  end

endmodule

// File: rtl/core_status_led.sv
// Per-core job status LEDs: tracks which cores finished a job, blinks the
// missing ones while running, shows all-on when complete and a steady mask
// with a blinking done LED on timeout. All outputs are registered.
module core_status_led
  import accel_status_pkg::*;
#(
  parameter int NUM_CORES   = DEF_NUM_CORES,
  parameter int BLINK_DIV   = DEF_BLINK_DIV,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] led,
  output logic                 led_done,
  output logic [1:0]           state
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  logic                 rst_meta;
  logic                 rst_sync;
  state_t               st;
  state_t               st_nxt;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] mask_nxt;
  logic [TW-1:0]        tcnt;
  logic [TW-1:0]        tcnt_nxt;
  logic [NUM_CORES-1:0] led_nxt;
  logic                 led_done_nxt;
  logic                 run_entry;
  logic                 pres_en;
  logic                 pres_clr;
  logic                 blink;
  logic                 blink_eff;

  // Reset synchronizer: assertion is immediate, release is aligned to clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .rst   (rst_sync),
    .en    (pres_en),
    .clr   (pres_clr),
    .blink (blink)
  );

  // Next state, sticky done mask, timeout counter and next output values
  always_comb begin
    st_nxt   = st;
    mask_nxt = mask;
    tcnt_nxt = '0;
    case (st)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) st_nxt = ST_RUN;
      end
      ST_RUN: begin
        mask_nxt = mask | core_done;
        if (&mask_nxt) begin
          st_nxt = ST_DONE;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          st_nxt = ST_FAULT;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase

    // A fresh job starts with nothing done and a dark blink phase
    run_entry = (st_nxt == ST_RUN) && (st != ST_RUN);
    if (run_entry) begin
      mask_nxt = '0;
      tcnt_nxt = '0;
    end

    pres_en   = (st_nxt == ST_RUN) || (st_nxt == ST_FAULT);
    pres_clr  = run_entry || !pres_en;
    blink_eff = run_entry ? 1'b0 : blink;

    led_nxt      = '0;
    led_done_nxt = 1'b0;
    case (st_nxt)
      ST_RUN:   led_nxt = mask_nxt | {NUM_CORES{blink_eff}};
      ST_DONE: begin
        led_nxt      = '1;
        led_done_nxt = 1'b1;
      end
      ST_FAULT: begin
        led_nxt      = mask_nxt;
        led_done_nxt = blink_eff;
      end
      default: led_nxt = '0;
    endcase
  end

  // State, mask, timeout and registered LED drives
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      st       <= ST_IDLE;
      mask     <= '0;
      tcnt     <= '0;
      led      <= '0;
      led_done <= 1'b0;
    end else begin
      st       <= st_nxt;
      mask     <= mask_nxt;
      tcnt     <= tcnt_nxt;
      led      <= led_nxt;
      led_done <= led_done_nxt;
    end
  end

  assign state = st;

endmodule
